// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide
// step per cycle, result returned through a one-cycle register-file write port.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dst,
  input  logic             kill,
  output logic             busy,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             we
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [1:0]           op_q;
  logic [AW-1:0]        dst_q;
  logic [WIDTH-1:0]     opb;    // multiplicand or divisor
  logic [2*WIDTH-1:0]   prod;   // {partial high word, remaining multiplier bits}
  logic [WIDTH:0]       rem;    // partial remainder, one spare bit for trial subtract
  logic [WIDTH-1:0]     quo;    // dividend bits shift out the top, quotient bits in the bottom

  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_nx;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       rem_nx;
  logic [WIDTH-1:0]     quo_nx;
  logic [WIDTH-1:0]     result;

  // One iteration of both datapaths plus the result selected by the latched op
  always_comb begin
    addend  = prod[0] ? {1'b0, opb} : '0;
    sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;
    prod_nx = {sum, prod[WIDTH-1:1]};

    shifted = (WIDTH+1)'({rem, quo[WIDTH-1]});
    trial   = shifted - {1'b0, opb};
    rem_nx  = shifted;
    quo_nx  = {quo[WIDTH-2:0], 1'b0};
    // A zero divisor never underflows, so every quotient bit becomes 1 and the
    // dividend ends up shifted intact into the remainder.
    if (!trial[WIDTH]) begin
      rem_nx = trial;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end

    unique case (op_q)
      2'b00:   result = prod_nx[WIDTH-1:0];
      2'b01:   result = prod_nx[2*WIDTH-1:WIDTH];
      2'b10:   result = quo_nx;
      default: result = rem_nx[WIDTH-1:0];
    endcase
  end

  // Control FSM, operand latching, iteration and registered write port
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      dst_q <= '0;
      opb   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            prod <= prod_nx;
            rem  <= rem_nx;
            quo  <= quo_nx;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              we    <= 1'b1;
              wa    <= dst_q;
              wd    <= result;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new op; DONE's write pulse ends here
          we <= 1'b0;
          if (start && !kill) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            op_q  <= op;
            dst_q <= dst;
            opb   <= b;
            prod  <= {{WIDTH{1'b0}}, a};
            rem   <= '0;
            quo   <= a;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences and
// random ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [AW-1:0] dst;
  logic          kill;
  logic          busy;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  logic          we;

  int n_chk      = 0;
  int n_fail     = 0;
  int we_count   = 0;
  int exp_writes = 0;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] dst;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[10];

  muldiv_unit #(.WIDTH(W), .AW(AW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .dst   (dst),
    .kill  (kill),
    .busy  (busy),
    .wa    (wa),
    .wd    (wd),
    .we    (we)
  );

  always #5 clk = ~clk;

  // Every cycle with we high is one register-file write
  always @(negedge clk) if (we === 1'b1) we_count++;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == 0) ? '1 : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present a request before an edge; returns just after the accepting edge E0
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [AW-1:0] d, input bit hold_start);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dst = d;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom; dst = AW'($urandom);
  endtask

  // Count cycles after E0 until we is seen (bounded); busy must be high until then
  task automatic wait_we(output int lat, output logic [AW-1:0] wa_s,
                         output logic [W-1:0] wd_s, output int busy_bad);
    lat = 0; busy_bad = 0; wa_s = 'x; wd_s = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (we === 1'b1) begin
        lat = k; wa_s = wa; wd_s = wd;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [AW-1:0] d, input logic [W-1:0] exp);
    int lat; int bb; logic [AW-1:0] wa_s; logic [W-1:0] wd_s;
    issue(o, x, y, d, 1'b0);
    wait_we(lat, wa_s, wd_s, bb);
    exp_writes++;
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy"}, 64'(bb), 64'd0);
    chk({nm, " wa"}, 64'(wa_s), 64'(d));
    chk({nm, " wd"}, 64'(wd_s), 64'(exp));
  endtask

  task automatic idle_check(input string nm, input int cycles);
    repeat (cycles) @(negedge clk);
    chk({nm, " write count"}, 64'(we_count), 64'(exp_writes));
  endtask

  initial begin
    int lat; int bb; logic [AW-1:0] wa_s; logic [W-1:0] wd_s;
    logic [1:0] ro; logic [W-1:0] ra; logic [W-1:0] rb; logic [AW-1:0] rd;

    vecs[0] = '{2'd0, 32'd7,          32'd6,          3'd3, 32'h0000002A};
    vecs[1] = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   3'd1, 32'hFFFFFFFE};
    vecs[2] = '{2'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   3'd2, 32'h00000001};
    vecs[3] = '{2'd2, 32'd100,        32'd7,          3'd4, 32'h0000000E};
    vecs[4] = '{2'd3, 32'd100,        32'd7,          3'd5, 32'h00000002};
    vecs[5] = '{2'd2, 32'h00001234,   32'd0,          3'd6, 32'hFFFFFFFF};
    vecs[6] = '{2'd3, 32'h00001234,   32'd0,          3'd7, 32'h00001234};
    vecs[7] = '{2'd2, 32'd5,          32'd9,          3'd1, 32'h00000000};
    vecs[8] = '{2'd1, 32'h80000000,   32'd4,          3'd2, 32'h00000002};
    vecs[9] = '{2'd3, 32'hFFFFFFFF,   32'h00000010,   3'd5, 32'h0000000F};

    n_rst = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0; dst = '0;
    #3;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset we",   64'(we),   64'd0);
    chk("reset wa",   64'(wa),   64'd0);
    chk("reset wd",   64'(wd),   64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                             vecs[i].b, vecs[i].dst, vecs[i].exp);
    idle_check("after table", 3);

    // Reset in the middle of RUN clears outputs at once and drops the op
    issue(2'd0, 32'd5, 32'd5, 3'd6, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset we",   64'(we),   64'd0);
    chk("async reset wa",   64'(wa),   64'd0);
    chk("async reset wd",   64'(wd),   64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle_check("after reset", 40);
    run_op("post-reset", 2'd0, 32'd11, 32'd13, 3'd4, 32'd143);

    // Back-to-back: divide then remainder, second start held through DONE
    issue(2'd2, 32'd100, 32'd7, 3'd5, 1'b0);
    repeat (31) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7; dst = 3'd6;
    @(negedge clk);
    chk("b2b busy last run cycle", 64'(busy), 64'd1);
    chk("b2b no early we", 64'(we), 64'd0);
    @(negedge clk);
    chk("b2b first we", 64'(we), 64'd1);
    chk("b2b first wa", 64'(wa), 64'd5);
    chk("b2b first wd", 64'(wd), 64'h0000000E);
    exp_writes++;
    @(posedge clk);
    #1 start = 1'b0; op = 2'd0; a = '1; b = '1; dst = '0;
    wait_we(lat, wa_s, wd_s, bb);
    exp_writes++;
    chk("b2b second latency", 64'(lat), 64'd33);
    chk("b2b second busy", 64'(bb), 64'd0);
    chk("b2b second wa", 64'(wa_s), 64'd6);
    chk("b2b second wd", 64'(wd_s), 64'h00000002);

    // Kill during RUN with start held high: no write, busy falls next cycle
    issue(2'd1, 32'hDEADBEEF, 32'h12345678, 3'd3, 1'b1);
    repeat (10) @(negedge clk);
    chk("kill pre busy", 64'(busy), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("kill busy", 64'(busy), 64'd0);
    idle_check("after kill", 40);
    run_op("post-kill", 2'd2, 32'd1000, 32'd10, 3'd2, 32'd100);

    // Kill plus start in DONE: the write stands, the start is dropped
    issue(2'd0, 32'd3, 32'd9, 3'd7, 1'b0);
    wait_we(lat, wa_s, wd_s, bb);
    exp_writes++;
    chk("done-kill latency", 64'(lat), 64'd33);
    chk("done-kill wd", 64'(wd_s), 64'd27);
    kill = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("done-kill busy", 64'(busy), 64'd0);
    idle_check("after done-kill", 40);

    // Random ops against the arithmetic model
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      rd = AW'($urandom);
      run_op($sformatf("rand%0d op%0d a=%h b=%h", n, ro, ra, rb), ro, ra, rb, rd,
             model(ro, ra, rb));
    end
    idle_check("final", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
